// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, non-stalling FP divider among NUM_REQ requesters.
// Per-requester credit counters bound outstanding divides; a tag pipe routes each quotient home.
module fp_div_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LATENCY      = 32,
    parameter int unsigned MAX_INFLIGHT = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [31:0]           div_a,
    output logic [31:0]           div_b,
    input  logic [31:0]           div_q,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [31:0]           resp_q,
    output logic                  busy
);

    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic [LATENCY-1:0] tag_v_q, tag_v_d;
    logic [ID_W-1:0]    tag_id_q [LATENCY];
    logic [ID_W-1:0]    tag_id_d [LATENCY];
    logic [CNT_W-1:0]   cnt_q [NUM_REQ];
    logic [CNT_W-1:0]   cnt_d [NUM_REQ];
    logic [ID_W-1:0]    last_q, last_d;

    logic [NUM_REQ-1:0] eligible;
    logic               issue;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    scan_idx;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        issue    = 1'b0;
        gnt_id   = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (cnt_q[i] < CNT_W'(MAX_INFLIGHT));
        end
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = ID_W'((32'(last_q) + k) % NUM_REQ);
            if (!issue && eligible[scan_idx]) begin
                issue  = 1'b1;
                gnt_id = scan_idx;
            end
        end
    end

    // Grant decode and operand mux toward the divider
    always_comb begin
        req_ready = '0;
        div_a     = '0;
        div_b     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (issue && (gnt_id == ID_W'(i))) begin
                req_ready[i] = 1'b1;
                div_a        = req_a[32*i +: 32];
                div_b        = req_b[32*i +: 32];
            end
        end
    end

    // Response routing from the oldest tag; quotient passes straight through
    always_comb begin
        resp_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = tag_v_q[LATENCY-1] && (tag_id_q[LATENCY-1] == ID_W'(i));
        end
        resp_q = div_q;
        busy   = |tag_v_q;
    end

    // Next state: tag shift, credit update, pointer update
    always_comb begin
        tag_v_d     = '0;
        tag_id_d    = tag_id_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        tag_v_d[0]  = issue;
        tag_id_d[0] = gnt_id;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && !resp_valid[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!req_ready[i] && resp_valid[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
        if (issue) begin
            last_d = gnt_id;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_v_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
            last_q <= ID_W'(NUM_REQ - 1);
        end else begin
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
        end
    end

endmodule
